rd_brst_capt: RTL and testbench
===============================

RD_BRST_CAPT -- requirements
Module: rd_brst_capt

Interface
REQ-001 SHALL have parameter DW, default 32: width of the SDRAM data bus and the user read data.
REQ-002 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port rd_cmd, input, 1: one-cycle pulse in the cycle the controller issues READ to the SDRAM.
REQ-005 SHALL have port cas_lat, input, 2: CAS latency in cycles; legal values 2 and 3.
REQ-006 SHALL have port brst_max, input, 3: burst length minus 1; beats = brst_max+1 (1..8).
REQ-007 SHALL have port sdr_dq_in, input, DW: data bus from the SDRAM pins.
REQ-008 SHALL have port usr_dout, output, DW: captured read beat.
REQ-009 SHALL have port usr_dvalid, output, 1: usr_dout holds a valid beat this cycle.
REQ-010 SHALL have port usr_dlast, output, 1: final beat of the burst; only high with usr_dvalid.
REQ-011 SHALL have port capt_busy, output, 1: capture in progress, from the cycle after rd_cmd through the last beat.
REQ-012 SHALL have port ovr_err, output, 1: sticky flag for a READ issued while busy.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT_CL -> BURST -> IDLE.
REQ-014 In IDLE, rd_cmd high SHALL latch cas_lat and brst_max, load the latency counter and enter WAIT_CL.
REQ-015 cas_lat values 0 and 1 SHALL be treated as 2; the value 3 SHALL be used as 3.
REQ-016 For rd_cmd at cycle T, beat k (k=0..brst_max) SHALL be sampled from sdr_dq_in at the end of cycle T+CL+k.
REQ-017 Beat k SHALL be presented on usr_dout, with usr_dvalid=1, in cycle T+CL+1+k.
REQ-018 usr_dvalid SHALL be high for exactly brst_max+1 consecutive cycles, with no gaps.
REQ-019 usr_dlast SHALL be high in the same cycle as the valid beat with k=brst_max.
REQ-020 The beat counter SHALL be 3 bits, load the latched brst_max, decrement per beat and signal the last beat at 0; it SHALL never wrap.
REQ-021 After the last beat the FSM SHALL return to IDLE; a new rd_cmd is accepted in the first cycle capt_busy=0.
REQ-022 rd_cmd while capt_busy=1 SHALL be ignored, with no effect on the burst in progress, and SHALL set ovr_err.
REQ-023 Changes to cas_lat or brst_max during a capture SHALL have no effect until the next accepted rd_cmd.
REQ-024 usr_dout SHALL hold its last value when usr_dvalid=0.

Reset
REQ-025 Reset=1 SHALL force state IDLE, both counters to 0 and usr_dvalid, usr_dlast, capt_busy and ovr_err to 0, and usr_dout to all zeros.
REQ-026 Reset asserted mid-burst SHALL abort the capture, with no further valid beats after reset deasserts.
REQ-027 Reset has priority over rd_cmd in the same cycle.
REQ-028 ovr_err SHALL clear only on reset.

Configuration
REQ-029 Macro RD_CAPT_IOREG_EN defined SHALL add an input register on sdr_dq_in, for an IOB flop.
REQ-030 With RD_CAPT_IOREG_EN, all beat timing in REQ-016/017 SHALL shift one cycle later, and capt_busy SHALL extend one cycle.
REQ-031 Without RD_CAPT_IOREG_EN, sdr_dq_in SHALL feed the capture register directly, with the timing exactly as in REQ-016/017.

Structure
REQ-032 Package sdram_pkg SHALL hold the FSM state enum, the CL2/CL3 constants and the burst-length encodings.
REQ-033 The latency and beat down-counter SHALL be one sub-module, rd_beat_cntr, instantiated twice: once for CAS-latency wait and once for beat counting.
REQ-034 The top level SHALL hold the FSM, the capture/output registers and the optional input register.

Verification
REQ-035 CL=2, brst_max=3, rd_cmd at T=10, sdr_dq_in=0xA0+cycle -> usr_dvalid in cycles 13..16, usr_dout 0xAC,0xAD,0xAE,0xAF, usr_dlast in cycle 16 only.
REQ-036 CL=3, brst_max=0, rd_cmd at T=5 -> a single beat in cycle 9 with usr_dlast=1; capt_busy high in cycles 6..9.
REQ-037 CL=2, brst_max=7, second rd_cmd at T+4 -> the second rd_cmd is ignored, 8 beats are delivered unchanged, and ovr_err=1 until reset.
REQ-038 rd_cmd pulsed in the first cycle capt_busy=0 after a burst -> the new burst is accepted with correct timing, and ovr_err stays 0.
REQ-039 Reset asserted in the cycle of beat 2 of a 4-beat burst -> all outputs 0 the next cycle, and no valid beats follow.
REQ-040 With RD_CAPT_IOREG_EN and the stimulus of REQ-035 -> usr_dvalid in cycles 14..17 with the same data values.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM read-burst capture path.
// RD_CAPT_IOREG_EN adds one cycle of input registering on the data bus.
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CL = 2'd1,
        BURST   = 2'd2
    } state_t;

    localparam logic [1:0] CL2 = 2'd2;
    localparam logic [1:0] CL3 = 2'd3;

    // brst_max encodings (beats minus one)
    typedef enum logic [2:0] {
        BL1 = 3'd0,
        BL2 = 3'd1,
        BL4 = 3'd3,
        BL8 = 3'd7
    } bl_t;

`ifdef RD_CAPT_IOREG_EN
    localparam logic [1:0] IO_DLY = 2'd1;
`else
    localparam logic [1:0] IO_DLY = 2'd0;
`endif

    // Cycles spent in WAIT_CL minus one; CAS latency 0/1 behave as 2.
    function automatic logic [1:0] lat_load(input logic [1:0] cl);
        if (cl == CL3)
            lat_load = CL3 - 2'd2 + IO_DLY;
        else
            lat_load = CL2 - 2'd2 + IO_DLY;
    endfunction

endpackage

// File: rtl/rd_beat_cntr.sv
// Loadable saturating down-counter used for CAS wait and beat counting.
// Build option RD_CAPT_IOREG_EN does not affect this module.
module rd_beat_cntr
    import sdram_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge Clk) begin
        if (Reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rd_brst_capt.sv
// SDRAM read-burst capture: waits CAS latency, then registers each beat.
// Define RD_CAPT_IOREG_EN to add an input register on sdr_dq_in.
module rd_brst_capt
    import sdram_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          rd_cmd,
    input  logic [1:0]    cas_lat,
    input  logic [2:0]    brst_max,
    input  logic [DW-1:0] sdr_dq_in,
    output logic [DW-1:0] usr_dout,
    output logic          usr_dvalid,
    output logic          usr_dlast,
    output logic          capt_busy,
    output logic          ovr_err
);

    state_t        state;
    state_t        nxt;
    logic [2:0]    brst_q;
    logic [1:0]    lat_cnt;
    logic          lat_zero;
    logic [2:0]    beat_cnt;
    logic          beat_zero;
    logic          accept;
    logic          lat_dec;
    logic          beat_ld;
    logic          beat_dec;
    logic          cap_en;
    logic [DW-1:0] cap_d;

    // Busy also covers the cycle the final beat is presented.
    assign capt_busy = (state != IDLE) || usr_dvalid;
    assign accept    = rd_cmd && !capt_busy;

`ifdef RD_CAPT_IOREG_EN
    logic [DW-1:0] dq_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            dq_q <= '0;
        else
            dq_q <= sdr_dq_in;
    end

    assign cap_d = dq_q;
`else
    assign cap_d = sdr_dq_in;
`endif

    rd_beat_cntr #(.W(2)) u_lat_cntr (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (accept),
        .load_val (lat_load(cas_lat)),
        .dec      (lat_dec),
        .cnt      (lat_cnt),
        .zero     (lat_zero)
    );

    rd_beat_cntr #(.W(3)) u_beat_cntr (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (beat_ld),
        .load_val (brst_q),
        .dec      (beat_dec),
        .cnt      (beat_cnt),
        .zero     (beat_zero)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt      = state;
        lat_dec  = 1'b0;
        beat_ld  = 1'b0;
        beat_dec = 1'b0;
        cap_en   = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    nxt = WAIT_CL;
            end
            WAIT_CL: begin
                lat_dec = 1'b1;
                if (lat_zero) begin
                    beat_ld = 1'b1;
                    nxt     = BURST;
                end
            end
            BURST: begin
                cap_en   = 1'b1;
                beat_dec = 1'b1;
                if (beat_zero)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            usr_dout   <= '0;
            usr_dvalid <= 1'b0;
            usr_dlast  <= 1'b0;
            ovr_err    <= 1'b0;
            brst_q     <= '0;
        end else begin
            usr_dvalid <= cap_en;
            usr_dlast  <= cap_en && beat_zero;
            if (cap_en)
                usr_dout <= cap_d;
            if (rd_cmd && capt_busy)
                ovr_err <= 1'b1;
            if (accept)
                brst_q <= brst_max;
        end
    end

    // Lower bits of the latency counter are only observed through lat_zero.
    logic unused_ok;
    assign unused_ok = ^{lat_cnt, beat_cnt};

endmodule

// File: tb/tb_rd_brst_capt.sv
// Self-checking bench for rd_brst_capt (vector table plus scoreboard).
// Honours RD_CAPT_IOREG_EN to expect the extra input-register cycle.
module tb_rd_brst_capt;

    localparam int DW = 32;
`ifdef RD_CAPT_IOREG_EN
    localparam int IO = 1;
`else
    localparam int IO = 0;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          rd_cmd = 1'b0;
    logic [1:0]    cas_lat = 2'd2;
    logic [2:0]    brst_max = 3'd0;
    logic [DW-1:0] sdr_dq_in;
    logic [DW-1:0] usr_dout;
    logic          usr_dvalid;
    logic          usr_dlast;
    logic          capt_busy;
    logic          ovr_err;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [1:0] cl;
        logic [2:0] bm;
        int         eff;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];

    rd_brst_capt #(.DW(DW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .rd_cmd     (rd_cmd),
        .cas_lat    (cas_lat),
        .brst_max   (brst_max),
        .sdr_dq_in  (sdr_dq_in),
        .usr_dout   (usr_dout),
        .usr_dvalid (usr_dvalid),
        .usr_dlast  (usr_dlast),
        .capt_busy  (capt_busy),
        .ovr_err    (ovr_err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    assign sdr_dq_in = DW'(32'hA0 + cyc);

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge Clk);
        chk("dlast_gate", 64'(usr_dlast & ~usr_dvalid), 64'd0);
        if (usr_dvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(usr_dvalid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("beat_data", 64'(usr_dout), 64'(e.data));
                chk("beat_last", 64'(usr_dlast), 64'(e.last));
                chk("beat_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic push_burst(input int t, input int eff,
                              input int bm, input int nb);
        exp_t e;
        for (int k = 0; k < nb; k++) begin
            e.data = DW'(32'hA0 + t + eff + k);
            e.last = (k == bm);
            e.cyc  = t + eff + 1 + IO + k;
            sb.push_back(e);
        end
    endtask

    task automatic pulse(input logic [1:0] cl, input logic [2:0] bm,
                         input int eff, input bit push, output int t);
        cas_lat  = cl;
        brst_max = bm;
        rd_cmd   = 1'b1;
        t        = cyc;
        if (push)
            push_burst(t, eff, int'(bm), int'(bm) + 1);
        step();
        rd_cmd = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (capt_busy === 1'b1 && n < 60) begin
            n++;
            step();
            cas_lat  = 2'($urandom);
            brst_max = 3'($urandom);
        end
    endtask

    initial begin
        int t;
        int n;

        tbl[0] = '{2'd2, 3'd3, 2};
        tbl[1] = '{2'd3, 3'd0, 3};
        tbl[2] = '{2'd0, 3'd7, 2};
        tbl[3] = '{2'd1, 3'd1, 2};
        tbl[4] = '{2'd3, 3'd5, 3};
        tbl[5] = '{2'd2, 3'd0, 2};
        tbl[6] = '{2'd3, 3'd7, 3};

        Reset = 1'b1;
        repeat (3) step();
        chk("rst_dvalid", 64'(usr_dvalid), 64'd0);
        chk("rst_dlast", 64'(usr_dlast), 64'd0);
        chk("rst_busy", 64'(capt_busy), 64'd0);
        chk("rst_ovr", 64'(ovr_err), 64'd0);
        chk("rst_dout", 64'(usr_dout), 64'd0);
        Reset = 1'b0;

        // Reference burst: CL2, 4 beats, command in cycle 10
        while (cyc < 10) step();
        pulse(2'd2, 3'd3, 2, 1'b1, t);
        wait_idle(n);
        chk("ref_busy_len", 64'(n), 64'(6 + IO));
        chk("ref_dout_hold", 64'(usr_dout), 64'h0AF);

        // Table, each command in the first idle cycle after the previous
        for (int i = 0; i < 7; i++) begin
            pulse(tbl[i].cl, tbl[i].bm, tbl[i].eff, 1'b1, t);
            wait_idle(n);
            chk("vec_busy_len", 64'(n),
                64'(tbl[i].eff + 1 + int'(tbl[i].bm) + IO));
            chk("vec_dout_hold", 64'(usr_dout),
                64'(32'hA0 + t + tbl[i].eff + int'(tbl[i].bm)));
        end
        chk("b2b_ovr_clear", 64'(ovr_err), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Overrun: second command 4 cycles into an 8-beat burst
        pulse(2'd2, 3'd7, 2, 1'b1, t);
        repeat (3) step();
        cas_lat  = 2'd3;
        brst_max = 3'd1;
        rd_cmd   = 1'b1;
        step();
        rd_cmd = 1'b0;
        chk("ovr_set", 64'(ovr_err), 64'd1);
        wait_idle(n);
        chk("ovr_busy_len", 64'(n), 64'(6 + IO));
        pulse(2'd3, 3'd1, 3, 1'b1, t);
        wait_idle(n);
        chk("ovr_sticky", 64'(ovr_err), 64'd1);
        chk("ovr_sb_drained", 64'(sb.size()), 64'd0);

        // Reset during beat 2 of a 4-beat burst
        pulse(2'd2, 3'd3, 2, 1'b0, t);
        push_burst(t, 2, 3, 3);
        repeat (4 + IO) step();
        chk("mid_beat2_valid", 64'(usr_dvalid), 64'd1);
        Reset = 1'b1;
        step();
        chk("mid_rst_dvalid", 64'(usr_dvalid), 64'd0);
        chk("mid_rst_dlast", 64'(usr_dlast), 64'd0);
        chk("mid_rst_busy", 64'(capt_busy), 64'd0);
        chk("mid_rst_ovr", 64'(ovr_err), 64'd0);
        chk("mid_rst_dout", 64'(usr_dout), 64'd0);
        Reset = 1'b0;
        repeat (12) step();
        chk("post_rst_busy", 64'(capt_busy), 64'd0);
        chk("post_rst_sb", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
